seq_start_restart_gen: RTL and testbench

Parametrised start/reset sequencer that drives the radix-4 core's `reset` and `start` pins. Each run has programmable reset, gap and start phases, then waits for the core's `done`. The block adds single-shot and continuous modes, a `done` timeout with automatic restart, abort on `enable` drop, and a saturating run counter. It sits between the testbench/top-level control and the radix-4 datapath, replacing fixed-count pulse generation.

---
 rtl/seq_gen_pkg.sv | 34 +++
 rtl/seq_start_restart_gen_if.sv | 39 +++
 rtl/phase_timer.sv | 37 +++
 rtl/seq_start_restart_gen.sv | 144 ++++++++++++++
 tb/tb_seq_start_restart_gen.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
//   Shared definitions for the start/restart sequencer: FSM state encoding,
//   default phase lengths and a helper that turns a phase length in cycles
//   into the value loaded into the shared down-counter.
// -----------------------------------------------------------------------------
package seq_gen_pkg;

  // 3-bit state encoding shared by the sequencer and anything that observes it.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_GAP   = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_COOL  = 3'd5
  } state_t;

  // Default phase lengths (cycles) and widths.
  localparam int DEF_RESET_CYCLES   = 2;
  localparam int DEF_GAP_CYCLES     = 1;
  localparam int DEF_START_CYCLES   = 3;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int DEF_TIMER_W        = 8;
  localparam int DEF_CNT_W          = 8;

  // The timer is loaded on state entry and the phase ends on the edge where
  // it reads zero, so an N-cycle phase loads N-1. Zero-length requests
  // (only legal for the timeout, where 0 means "disabled") load 0.
  function automatic int phase_load(input int cycles);
    return (cycles > 0) ? cycles - 1 : 0;
  endfunction

endpackage : seq_gen_pkg

// File: rtl/seq_start_restart_gen_if.sv
// -----------------------------------------------------------------------------
// seq_start_restart_gen_if
//   Control/status bundle between the top-level controller and the sequencer.
//   master : the sequencer (drives the core's reset/start and status)
//   slave  : the controller side (drives enable/cont, forwards core done)
//   Signals:
//     enable    - level, 1 requests runs, 0 aborts
//     cont      - continuous mode select, sampled when done is accepted
//     done      - completion from the core
//     reset     - active-high synchronous reset to the core
//     start     - start strobe to the core
//     busy      - sequencer not idle
//     timeout   - one-cycle pulse when the wait for done expires
//     run_count - saturating count of accepted done events
// -----------------------------------------------------------------------------
interface seq_start_restart_gen_if #(
  parameter int CNT_W = seq_gen_pkg::DEF_CNT_W
) ();

  logic             enable;
  logic             cont;
  logic             done;
  logic             reset;
  logic             start;
  logic             busy;
  logic             timeout;
  logic [CNT_W-1:0] run_count;

  modport master (
    input  enable, cont, done,
    output reset, start, busy, timeout, run_count
  );

  modport slave (
    output enable, cont, done,
    input  reset, start, busy, timeout, run_count
  );

endinterface : seq_start_restart_gen_if

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   Loadable down-counter shared by every phase of the sequencer. It holds at
//   zero once it gets there, so expired stays high until the next load.
//   Ports:
//     clk, reset_n - clock, asynchronous active-low reset
//     load         - reload the counter with value this cycle
//     value        - reload value (phase length minus one)
//     expired      - counter is zero
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int W = seq_gen_pkg::DEF_TIMER_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count_q;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule : phase_timer

// File: rtl/seq_start_restart_gen.sv
// -----------------------------------------------------------------------------
// seq_start_restart_gen
//   Start/reset sequencer for the radix-4 core. A run is RESET_CYCLES of
//   core reset, GAP_CYCLES idle, START_CYCLES of start, then a wait for done.
//   Accepted done bumps a saturating run counter and either idles (cont=0)
//   or cools down for GAP_CYCLES and starts again (cont=1). A wait longer
//   than TIMEOUT_CYCLES (0 = never) pulses timeout and restarts the run.
//   Dropping enable aborts to IDLE from any state.
//   Ports:
//     clk     - clock, rising edge
//     reset_n - asynchronous active-low reset (core held in reset meanwhile)
//     bus     - master side of seq_start_restart_gen_if
// -----------------------------------------------------------------------------
module seq_start_restart_gen
  import seq_gen_pkg::*;
#(
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int START_CYCLES   = DEF_START_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TIMER_W        = DEF_TIMER_W,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  seq_start_restart_gen_if.master bus
);

  localparam logic [TIMER_W-1:0] LD_RST   = TIMER_W'(phase_load(RESET_CYCLES));
  localparam logic [TIMER_W-1:0] LD_GAP   = TIMER_W'(phase_load(GAP_CYCLES));
  localparam logic [TIMER_W-1:0] LD_START = TIMER_W'(phase_load(START_CYCLES));
  localparam logic [TIMER_W-1:0] LD_WAIT  = TIMER_W'(phase_load(TIMEOUT_CYCLES));
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam bit                 TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t             state_q;
  state_t             nxt_state;
  logic               reset_q;
  logic               start_q;
  logic               busy_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept_done;
  logic               fire_timeout;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_expired;

  // ---------------------------------------------------------------------------
  // Transition decisions. timeout_q doubles as "restart committed": the cycle
  // the timeout pulse is visible the FSM is still in WAIT, done is no longer
  // honoured, and the next edge enters RST.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    nxt_state    = state_q;
    accept_done  = 1'b0;
    fire_timeout = 1'b0;

    case (state_q)
      ST_IDLE:  if (bus.enable)  nxt_state = ST_RST;
      ST_RST:   if (tmr_expired) nxt_state = ST_GAP;
      ST_GAP:   if (tmr_expired) nxt_state = ST_START;
      ST_START: if (tmr_expired) nxt_state = ST_WAIT;
      ST_WAIT: begin
        if (timeout_q) begin
          nxt_state = ST_RST;
        end else if (bus.done) begin
          // done beats a timeout landing on the same cycle
          accept_done = 1'b1;
          nxt_state   = bus.cont ? ST_COOL : ST_IDLE;
        end else if (TO_EN && tmr_expired) begin
          fire_timeout = 1'b1;
        end
      end
      ST_COOL:  if (tmr_expired) nxt_state = ST_RST;
      default:  nxt_state = ST_IDLE;
    endcase

    // Abort overrides everything, including an accepted done.
    if (state_q != ST_IDLE && !bus.enable) begin
      nxt_state    = ST_IDLE;
      accept_done  = 1'b0;
      fire_timeout = 1'b0;
    end
  end

  // Reload the shared timer with the new phase length on every state entry.
  always_comb begin
    tmr_load = (nxt_state != state_q);
    case (nxt_state)
      ST_RST:           tmr_value = LD_RST;
      ST_GAP, ST_COOL:  tmr_value = LD_GAP;
      ST_START:         tmr_value = LD_START;
      ST_WAIT:          tmr_value = LD_WAIT;
      default:          tmr_value = '0;
    endcase
  end

  phase_timer #(
    .W (TIMER_W)
  ) u_phase_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // ---------------------------------------------------------------------------
  // State, registered outputs and the saturating run counter. Outputs are
  // decoded from the state being entered so they line up with it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      // NOTE: the core reset output resets to 1, not 0: the core must be held
      // in reset for as long as this block is.
      reset_q   <= 1'b1;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= nxt_state;
      reset_q   <= (nxt_state == ST_RST);
      start_q   <= (nxt_state == ST_START);
      busy_q    <= (nxt_state != ST_IDLE);
      timeout_q <= fire_timeout;
      if (accept_done && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.reset     = reset_q;
  assign bus.start     = start_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;
  assign bus.run_count = cnt_q;

endmodule : seq_start_restart_gen

// File: tb/tb_seq_start_restart_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_start_restart_gen
//   Two sequencers (8-bit and 2-bit run counters) share one stimulus stream.
//   A queue-based reference model plans each run as a list of output cycles
//   and is compared against both DUTs every cycle; directed scenarios add
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_seq_start_restart_gen;
  import seq_gen_pkg::*;

  localparam int R  = 2;
  localparam int G  = 1;
  localparam int S  = 3;
  localparam int TO = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_start_restart_gen_if #(.CNT_W(8)) bus_a ();
  seq_start_restart_gen_if #(.CNT_W(2)) bus_b ();

  assign bus_b.enable = bus_a.enable;
  assign bus_b.cont   = bus_a.cont;
  assign bus_b.done   = bus_a.done;

  seq_start_restart_gen #(
    .RESET_CYCLES(R), .GAP_CYCLES(G), .START_CYCLES(S),
    .TIMEOUT_CYCLES(TO), .TIMER_W(8), .CNT_W(8)
  ) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a.master));

  seq_start_restart_gen #(
    .RESET_CYCLES(R), .GAP_CYCLES(G), .START_CYCLES(S),
    .TIMEOUT_CYCLES(TO), .TIMER_W(8), .CNT_W(2)
  ) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b.master));

  // ---------------------------------------------------------------- model ---
  typedef struct packed {
    logic reset;
    logic start;
    logic busy;
    logic timeout;
  } outs_t;

  localparam outs_t O_IDLE  = '{reset: 1'b0, start: 1'b0, busy: 1'b0, timeout: 1'b0};
  localparam outs_t O_HELD  = '{reset: 1'b1, start: 1'b0, busy: 1'b0, timeout: 1'b0};
  localparam outs_t O_RST   = '{reset: 1'b1, start: 1'b0, busy: 1'b1, timeout: 1'b0};
  localparam outs_t O_BUSY  = '{reset: 1'b0, start: 1'b0, busy: 1'b1, timeout: 1'b0};
  localparam outs_t O_START = '{reset: 1'b0, start: 1'b1, busy: 1'b1, timeout: 1'b0};
  localparam outs_t O_TOUT  = '{reset: 1'b0, start: 1'b0, busy: 1'b1, timeout: 1'b1};

  outs_t plan[$];   // outputs for the coming cycles of the current run
  outs_t exp_o;     // expected outputs for the cycle after the last edge
  bit    active;    // a run is in progress (not idle)
  bit    waiting;   // waiting for done
  int    wcnt;      // wait cycles elapsed
  int    runs;      // accepted done events since reset (unsaturated)

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // continuous-mode spacing tracker
  int drive_cyc;
  bit have_drive;
  bit prev_reset;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic push_run();
    repeat (R) plan.push_back(O_RST);
    repeat (G) plan.push_back(O_BUSY);
    repeat (S) plan.push_back(O_START);
  endtask

  task automatic model_reset();
    active  = 1'b0;
    waiting = 1'b0;
    wcnt    = 0;
    runs    = 0;
    plan.delete();
    exp_o   = O_HELD;
  endtask

  // One rising edge of the reference: inputs sampled, next-cycle outputs planned.
  task automatic model_step();
    if (!reset_n) begin
      model_reset();
    end else if (!active) begin
      if (bus_a.enable) begin
        active = 1'b1;
        plan.delete();
        push_run();
        exp_o = plan.pop_front();
      end else begin
        exp_o = O_IDLE;
      end
    end else if (!bus_a.enable) begin
      active  = 1'b0;
      waiting = 1'b0;
      plan.delete();
      exp_o   = O_IDLE;
    end else if (plan.size() > 0) begin
      exp_o = plan.pop_front();
    end else if (!waiting) begin
      waiting = 1'b1;
      wcnt    = 0;
      exp_o   = O_BUSY;
    end else begin
      wcnt++;
      if (bus_a.done) begin
        runs++;
        waiting = 1'b0;
        if (bus_a.cont) begin
          repeat (G) plan.push_back(O_BUSY);
          push_run();
          exp_o = plan.pop_front();
        end else begin
          active = 1'b0;
          exp_o  = O_IDLE;
        end
      end else if (TO != 0 && wcnt == TO) begin
        waiting = 1'b0;
        push_run();
        exp_o = O_TOUT;
      end else begin
        exp_o = O_BUSY;
      end
    end
  endtask

  task automatic compare();
    check("outs_a", {bus_a.reset, bus_a.start, bus_a.busy, bus_a.timeout}, exp_o);
    check("outs_b", {bus_b.reset, bus_b.start, bus_b.busy, bus_b.timeout}, exp_o);
    check("cnt_a", bus_a.run_count, sat(runs, 255));
    check("cnt_b", bus_b.run_count, sat(runs, 3));
  endtask

  task automatic do_cycle();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
  task automatic apply_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_reset", bus_a.reset, 1);
    check("arst_start", bus_a.start, 0);
    check("arst_busy", bus_a.busy, 0);
    check("arst_cnt", bus_a.run_count, 0);
    @(negedge clk);
    do_cycle();
    do_cycle();
    reset_n = 1'b1;
  endtask

  task automatic track_gap();
    if (bus_a.reset && !prev_reset && have_drive) begin
      check("cont_gap", cyc - drive_cyc, 2);
      have_drive = 1'b0;
    end
    prev_reset = bus_a.reset;
  endtask

  // ------------------------------------------------------------- stimulus ---
  initial begin : main
    bit rp[12] = '{1,1,0,0,0,0,0,0,0,0,0,0};
    bit sp[12] = '{0,0,0,1,1,1,0,0,0,0,0,0};
    bit bp[12] = '{1,1,1,1,1,1,1,1,1,1,1,0};
    int t_k, r_k, guard;

    bus_a.enable = 1'b0;
    bus_a.cont   = 1'b0;
    bus_a.done   = 1'b0;
    model_reset();
    repeat (3) do_cycle();
    check("rst_hold_reset", bus_a.reset, 1);
    reset_n = 1'b1;
    do_cycle();
    check("first_edge_reset", bus_a.reset, 0);
    repeat (2) do_cycle();

    // Single shot: done sampled 5 cycles after start falls.
    bus_a.enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus_a.done = (k == 11);
      do_cycle();
      check("ss_reset", bus_a.reset, rp[k]);
      check("ss_start", bus_a.start, sp[k]);
      check("ss_busy", bus_a.busy, bp[k]);
    end
    bus_a.done   = 1'b0;
    bus_a.enable = 1'b0;
    check("ss_count", bus_a.run_count, 1);
    repeat (3) do_cycle();

    // Abort in START cycle 2; done during START ignored.
    bus_a.enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus_a.done = (k == 4);
      if (k == 5) bus_a.enable = 1'b0;
      do_cycle();
      if (k == 4) check("ab_start_c2", bus_a.start, 1);
      if (k == 5) begin
        check("ab_start_low", bus_a.start, 0);
        check("ab_busy_low", bus_a.busy, 0);
      end
    end
    bus_a.done = 1'b0;
    check("ab_count", bus_a.run_count, 1);

    // Timeout with auto-restart.
    bus_a.enable = 1'b1;
    t_k = -1;
    r_k = -1;
    for (int k = 0; k < 30; k++) begin
      do_cycle();
      if (bus_a.timeout && t_k < 0) t_k = k;
      if (t_k >= 0 && k > t_k && bus_a.reset && r_k < 0) r_k = k;
    end
    check("to_cycle", t_k, 22);
    check("to_restart", r_k, 23);
    check("to_count", bus_a.run_count, 1);
    bus_a.enable = 1'b0;
    do_cycle();

    // Continuous mode, 4 runs, then abort.
    apply_reset();
    bus_a.cont   = 1'b1;
    bus_a.enable = 1'b1;
    have_drive   = 1'b0;
    prev_reset   = bus_a.reset;
    guard        = 0;
    while (runs < 4 && guard < 300) begin
      bus_a.done = waiting;
      if (waiting) begin
        drive_cyc  = cyc;
        have_drive = 1'b1;
      end
      do_cycle();
      track_gap();
      guard++;
    end
    check("cont_bound", guard < 300, 1);
    bus_a.done = 1'b0;
    do_cycle();
    track_gap();
    bus_a.enable = 1'b0;
    do_cycle();
    check("cont_busy", bus_a.busy, 0);
    check("cont_cnt_a", bus_a.run_count, 4);
    check("cont_cnt_b", bus_b.run_count, 3);

    // Fifth run: 2-bit counter stays saturated.
    bus_a.cont   = 1'b0;
    bus_a.enable = 1'b1;
    guard        = 0;
    while (!(runs == 5 && !active) && guard < 100) begin
      bus_a.done = waiting;
      do_cycle();
      guard++;
    end
    check("sat_bound", guard < 100, 1);
    bus_a.done   = 1'b0;
    bus_a.enable = 1'b0;
    do_cycle();
    check("sat_cnt_a", bus_a.run_count, 5);
    check("sat_cnt_b", bus_b.run_count, 3);

    // Reset pulse while waiting for done.
    bus_a.enable = 1'b1;
    guard        = 0;
    while (!(waiting && wcnt >= 3) && guard < 50) begin
      do_cycle();
      guard++;
    end
    check("wait_bound", guard < 50, 1);
    apply_reset();
    bus_a.enable = 1'b0;
    repeat (2) do_cycle();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) bus_a.enable = ~bus_a.enable;
      bus_a.cont = 1'($urandom_range(0, 1));
      bus_a.done = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 999) == 0) apply_reset();
      do_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_start_restart_gen
